seq_mult: RTL and testbench

- Iterative unsigned shift-add multiplier for the calculator datapath.
- Complements the restoring divider: same operand width, same operand-select style, opposite arithmetic direction.
- Takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product after a fixed WIDTH-cycle iteration.
- Reports completion with a one-cycle done strobe.
- Sits beside the divider under the calculator operation-select logic.

---
 rtl/seq_mult.sv | 90 +++++++++
 tb/tb_seq_mult.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Iterative unsigned shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product.
// Fixed WIDTH-cycle iteration with a one-cycle done strobe; accepts back-to-back starts from DONE.
module seq_mult #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | iterating, one multiplier bit per cycle
    // DONE  | product valid for one cycle; start here begins a new operation
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int               CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 w_accept;
    logic                 w_last;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_state == S_CALC) && (r_cnt == LAST);
    assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_CALC : S_IDLE;
            S_CALC:  w_next = w_last ? S_DONE : S_CALC;
            S_DONE:  w_next = start ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, in1};
            r_mplier <= in2;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_product <= w_sum;
            end
        end
    end

    // Outputs decode only from state/registers, so no input-to-output paths exist.
    assign busy    = (r_state == S_CALC);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult (WIDTH=5): latency, strobes, ignored starts,
// back-to-back operation and asynchronous reset mid-run.
module tb_seq_mult;

    localparam int WIDTH = 5;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int checks;
    int passes;

    seq_mult #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (busy !== 1'b0) $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); else passes++;
            checks++; if (done !== 1'b0) $display("FAIL reset_done cyc=%0d got=%b exp=0", i, done); else passes++;
            checks++; if (product !== 10'd0) $display("FAIL reset_product cyc=%0d got=%0d exp=0", i, product); else passes++;
        end
    endtask

    // 31*31: busy edges k..k+4, done after k+5 only, product stable until completion.
    task automatic test_basic();
        in1   = 5'd31;
        in2   = 5'd31;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (busy !== 1'b1) $display("FAIL basic_busy cyc=%0d got=%b exp=1", i, busy); else passes++;
            checks++; if (done !== 1'b0) $display("FAIL basic_early_done cyc=%0d got=%b exp=0", i, done); else passes++;
            checks++; if (product !== 10'd0) $display("FAIL basic_product_hold cyc=%0d got=%0d exp=0", i, product); else passes++;
            step();
        end
        checks++; if (done !== 1'b1) $display("FAIL basic_done got=%b exp=1", done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_busy_in_done got=%b exp=0", busy); else passes++;
        checks++; if (product !== 10'd961) $display("FAIL basic_product got=%0d exp=961", product); else passes++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", done); else passes++;
        checks++; if (product !== 10'd961) $display("FAIL basic_product_after got=%0d exp=961", product); else passes++;
    endtask

    // Zero and unit multiplicand: still exactly five iterations each.
    task automatic test_edge_operands();
        logic [WIDTH-1:0]   a [2];
        logic [WIDTH-1:0]   b [2];
        logic [2*WIDTH-1:0] exp_p [2];
        a[0] = 5'd0; b[0] = 5'd17; exp_p[0] = 10'd0;
        a[1] = 5'd1; b[1] = 5'd23; exp_p[1] = 10'd23;
        for (int t = 0; t < 2; t++) begin
            in1   = a[t];
            in2   = b[t];
            start = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < 5; i++) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL edge_timing t=%0d cyc=%0d got busy=%b done=%b exp busy=1 done=0", t, i, busy, done); else passes++;
                step();
            end
            checks++; if (done !== 1'b1) $display("FAIL edge_done t=%0d got=%b exp=1", t, done); else passes++;
            checks++; if (product !== exp_p[t]) $display("FAIL edge_product t=%0d got=%0d exp=%0d", t, product, exp_p[t]); else passes++;
            step();
        end
    endtask

    // 6*7 with a second start during CALC and operands changed mid-run.
    task automatic test_ignore_busy();
        in1   = 5'd6;
        in2   = 5'd7;
        start = 1'b1;
        step();                     // edge k
        start = 1'b0;
        in1   = 5'd3;
        in2   = 5'd3;
        step();                     // edge k+1
        start = 1'b1;
        step();                     // edge k+2: ignored
        start = 1'b0;
        step();                     // k+3
        step();                     // k+4
        checks++; if (done !== 1'b0) $display("FAIL ignore_early_done got=%b exp=0", done); else passes++;
        step();                     // k+5
        checks++; if (done !== 1'b1) $display("FAIL ignore_done got=%b exp=1", done); else passes++;
        checks++; if (product !== 10'd42) $display("FAIL ignore_product got=%0d exp=42", product); else passes++;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_queued cyc=%0d got busy=%b done=%b exp 0 0", i, busy, done); else passes++;
        end
        checks++; if (product !== 10'd42) $display("FAIL ignore_product_hold got=%0d exp=42", product); else passes++;
    endtask

    // start held high: re-accepted in DONE, second done six cycles after the first.
    task automatic test_back_to_back();
        in1   = 5'd5;
        in2   = 5'd9;
        start = 1'b1;
        for (int i = 0; i < 5; i++) step();     // edges k..k+4
        checks++; if (done !== 1'b0) $display("FAIL b2b_early_done got=%b exp=0", done); else passes++;
        step();                                 // k+5
        checks++; if (done !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", done); else passes++;
        checks++; if (product !== 10'd45) $display("FAIL b2b_first_product got=%0d exp=45", product); else passes++;
        in1 = 5'd4;
        in2 = 5'd4;
        step();                                 // k+6: accepted from DONE
        checks++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_restart got busy=%b done=%b exp busy=1 done=0", busy, done); else passes++;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (done !== 1'b0) $display("FAIL b2b_gap cyc=%0d got=%b exp=0", i, done); else passes++;
            checks++; if (product !== 10'd45) $display("FAIL b2b_hold cyc=%0d got=%0d exp=45", i, product); else passes++;
        end
        step();                                 // k+11
        checks++; if (done !== 1'b1) $display("FAIL b2b_second_done got=%b exp=1", done); else passes++;
        checks++; if (product !== 10'd16) $display("FAIL b2b_second_product got=%0d exp=16", product); else passes++;
        step();
    endtask

    // Asynchronous reset mid-run clears everything at once; nothing survives it.
    task automatic test_reset_mid();
        in1   = 5'd12;
        in2   = 5'd10;
        start = 1'b1;
        step();                     // edge k
        start = 1'b0;
        step();
        step();
        step();                     // edge k+3
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", done); else passes++;
        checks++; if (product !== 10'd0) $display("FAIL rstmid_product got=%0d exp=0", product); else passes++;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_residual cyc=%0d got busy=%b done=%b exp 0 0", i, busy, done); else passes++;
        end
        in1   = 5'd2;
        in2   = 5'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (done !== 1'b1) $display("FAIL rstmid_next_done got=%b exp=1", done); else passes++;
        checks++; if (product !== 10'd6) $display("FAIL rstmid_next_product got=%0d exp=6", product); else passes++;
        step();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        in1    = '0;
        in2    = '0;
        test_reset();
        test_basic();
        test_edge_operands();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
